// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the windowed sum accumulator.
package sum_acc_pkg;

    // Default widths: 16 samples of 8 bits need at most 12 bits of total.
    localparam int SUM_W_DEFAULT = 8;
    localparam int ACC_W_DEFAULT = 12;

    // win_len is 4 bits wide; the sample counter needs one more bit to hold 16.
    localparam int LEN_W = 4;
    localparam int CNT_W = LEN_W + 1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator.sv
// Windowed accumulator: after a start request it takes win_len samples
// (0 means 16) from the upstream adder and reports their total, maximum and
// minimum. The result is held with out_valid until the consumer accepts it.
// The result registers are separate from the working registers, so a new
// window never disturbs the previous result until that window completes.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] win_len,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [SUM_W-1:0] max_out,
    output logic [SUM_W-1:0] min_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] max_q;
    logic [SUM_W-1:0] min_q;

    logic             xfer;
    logic [CNT_W-1:0] count_next;
    logic [ACC_W-1:0] acc_next;
    logic [SUM_W-1:0] max_next;
    logic [SUM_W-1:0] min_next;
    logic             last_xfer;

    // Working values for a sample accepted this cycle (unsigned compares).
    always_comb begin
        xfer       = sum_valid & sum_ready;
        count_next = count + CNT_W'(1);
        acc_next   = acc + ACC_W'(sum_in);
        max_next   = (sum_in > max_q) ? sum_in : max_q;
        min_next   = (sum_in < min_q) ? sum_in : min_q;
        last_xfer  = xfer && (count_next == len_q);
    end

    // Controller, working registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            acc       <= '0;
            max_q     <= '0;
            min_q     <= '1;
            acc_out   <= '0;
            max_out   <= '0;
            min_out   <= '1;
            out_valid <= 1'b0;
            sum_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // A zero length code stands for a full 16-sample window.
                        len_q     <= (win_len == '0) ? CNT_W'(16) : CNT_W'(win_len);
                        count     <= '0;
                        acc       <= '0;
                        max_q     <= '0;
                        min_q     <= '1;
                        sum_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        count <= count_next;
                        acc   <= acc_next;
                        max_q <= max_next;
                        min_q <= min_next;
                    end
                    // The final sample is folded straight into the result registers.
                    if (last_xfer) begin
                        acc_out   <= acc_next;
                        max_out   <= max_next;
                        min_out   <= min_next;
                        out_valid <= 1'b1;
                        sum_ready <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    sum_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
